// File: rtl/trace_mem_ctrl.sv
// Trace memory controller: ring buffer with trigger-relative capture window in
// trace mode, plain FIFO between Tracer store and load sides in stream modes.
module trace_mem_ctrl #(
  parameter int TRB_WIDTH = 32,
  parameter int TRB_DEPTH = 64,
  parameter int ADDR_W    = $clog2(TRB_DEPTH)
) (
  input  logic                         FPGA_CLK_I,
  input  logic                         RST_I,
  input  logic [1:0]                   MODE_I,
  input  logic [ADDR_W-1:0]            TRG_DELAY_I,
  input  logic                         TRG_EVENT_I,
  input  logic [$clog2(TRB_WIDTH)-1:0] EVENT_POS_I,
  input  logic [TRB_WIDTH-1:0]         DATA_I,
  input  logic                         STORE_I,
  output logic                         STORE_PERM_O,
  input  logic                         LOAD_REQUEST_I,
  output logic                         LOAD_GRANT_O,
  output logic [TRB_WIDTH-1:0]         DATA_O,
  output logic                         TRG_DELAYED_O,
  output logic [ADDR_W-1:0]            EVENT_ADDR_O,
  output logic [$clog2(TRB_WIDTH)-1:0] EVENT_POS_O,
  output logic [ADDR_W:0]              WORD_COUNT_O
);

  localparam int PW = $clog2(TRB_WIDTH);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(TRB_DEPTH);
  localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  typedef enum logic [1:0] {ARMED, TRIGGERED, DONE} state_t;

  logic [TRB_WIDTH-1:0] mem [TRB_DEPTH];

  state_t              state_q, state_d;
  logic [1:0]          mode_q;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   post_q, post_d, dly_q, dly_d;
  logic [ADDR_W-1:0]   evt_addr_q, evt_addr_d;
  logic [PW-1:0]       evt_pos_q, evt_pos_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                trg_dly_q, trg_dly_d, seen_q, seen_d, prev_q;
  logic                grant_q, grant_d;
  logic [TRB_WIDTH-1:0] data_q;

  logic trace, perm, store, avail, load, trg_edge, to_done;

  assign trace    = (mode_q == 2'd0);
  assign trg_edge = TRG_EVENT_I & ~prev_q & ~seen_q;
  assign perm     = trace ? (state_q != DONE) : (cnt_q < DEPTH_C);
  assign store    = STORE_I & perm;
  assign avail    = (cnt_q != '0) & (~trace | (state_q == DONE));
  // Grant cycle blocks re-sampling, so grants come at most every other cycle.
  assign load     = LOAD_REQUEST_I & ~grant_q & avail;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    post_d     = post_q;
    dly_d      = dly_q;
    evt_addr_d = evt_addr_q;
    evt_pos_d  = evt_pos_q;
    trg_dly_d  = trg_dly_q;
    seen_d     = seen_q;
    grant_d    = load;
    to_done    = 1'b0;

    if (store) wr_ptr_d = wr_ptr_q + ONE_A;
    if (load)  rd_ptr_d = rd_ptr_q + ONE_A;
    if (store && !load && cnt_q != DEPTH_C) cnt_d = cnt_q + ONE_C;
    else if (load && !store)                cnt_d = cnt_q - ONE_C;

    if (trg_edge) begin
      seen_d     = 1'b1;
      evt_addr_d = wr_ptr_q;
      evt_pos_d  = EVENT_POS_I;
      if (!trace) trg_dly_d = 1'b1;
    end

    if (trace) begin
      case (state_q)
        ARMED: if (trg_edge) begin
          // Port width already bounds the delay to TRB_DEPTH-1.
          dly_d   = TRG_DELAY_I;
          post_d  = '0;
          state_d = TRIGGERED;
          if (store) begin
            if (TRG_DELAY_I == '0) to_done = 1'b1;
            else                   post_d  = ONE_A;
          end
        end
        TRIGGERED: if (store) begin
          if (post_q == dly_q) to_done = 1'b1;
          else                 post_d  = post_q + ONE_A;
        end
        default: ;
      endcase
    end

    if (to_done) begin
      state_d   = DONE;
      trg_dly_d = 1'b1;
      rd_ptr_d  = (cnt_d == DEPTH_C) ? wr_ptr_d : '0;
    end
  end

  always_ff @(posedge FPGA_CLK_I) begin
    if (store) mem[wr_ptr_q] <= DATA_I;
  end

  always_ff @(posedge FPGA_CLK_I) begin
    prev_q <= TRG_EVENT_I;
    if (RST_I) begin
      mode_q     <= MODE_I;
      state_q    <= ARMED;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      post_q     <= '0;
      dly_q      <= '0;
      evt_addr_q <= '0;
      evt_pos_q  <= '0;
      trg_dly_q  <= 1'b0;
      seen_q     <= 1'b0;
      grant_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      post_q     <= post_d;
      dly_q      <= dly_d;
      evt_addr_q <= evt_addr_d;
      evt_pos_q  <= evt_pos_d;
      trg_dly_q  <= trg_dly_d;
      seen_q     <= seen_d;
      grant_q    <= grant_d;
      if (load) data_q <= mem[rd_ptr_q];
    end
  end

  assign STORE_PERM_O  = perm;
  assign LOAD_GRANT_O  = grant_q;
  assign DATA_O        = data_q;
  assign TRG_DELAYED_O = trg_dly_q;
  assign EVENT_ADDR_O  = evt_addr_q;
  assign EVENT_POS_O   = evt_pos_q;
  assign WORD_COUNT_O  = (trace && state_q != DONE) ? '0 : cnt_q;

endmodule

// File: doc/trace_mem_ctrl.md
Name: trace_mem_ctrl

Overview:
Memory-side partner of the Tracer block. It accepts deserialised trace words on the Tracer store interface (DATA/STORE/STORE_PERM) and serves words back on the load interface (LOAD_REQUEST/LOAD_GRANT). In trace mode it is a ring buffer with a trigger-relative post-capture window and drives TRG_DELAYED back to the Tracer. In stream modes it is a plain FIFO between the Tracer store and load sides.

Parameters:
TRB_WIDTH, 32, trace word width in bits
TRB_DEPTH, 64, number of words in storage; power of two, at least 4
ADDR_W, $clog2(TRB_DEPTH), address width (derived)

Ports:
FPGA_CLK_I  in  1  single clock
RST_I  in  1  synchronous, active-high reset
MODE_I  in  2  trg_mode_t: 0 trace_mode, 1 rw_stream, 2 w_stream, 3 r_stream; sampled only under reset
TRG_DELAY_I  in  ADDR_W  number of words to store after the event word; sampled at the trigger edge
TRG_EVENT_I  in  1  Tracer TRG_EVENT_O (level)
EVENT_POS_I  in  $clog2(TRB_WIDTH)  Tracer EVENT_POS_O
DATA_I  in  TRB_WIDTH  word to store
STORE_I  in  1  store strobe; honoured only when STORE_PERM_O=1
STORE_PERM_O  out  1  permission to store
LOAD_REQUEST_I  in  1  read request, level
LOAD_GRANT_O  out  1  one-cycle pulse; DATA_O valid in the same cycle
DATA_O  out  TRB_WIDTH  read word
TRG_DELAYED_O  out  1  capture complete (trace mode) or event seen (stream modes)
EVENT_ADDR_O  out  ADDR_W  latched address of the event word
EVENT_POS_O  out  $clog2(TRB_WIDTH)  latched bit position of the event
WORD_COUNT_O  out  ADDR_W+1  words currently readable

Behaviour:
- Reset: all pointers and counters = 0; state = ARMED; outputs STORE_PERM_O=1, LOAD_GRANT_O=0, DATA_O=0, TRG_DELAYED_O=0, EVENT_ADDR_O=0, EVENT_POS_O=0, WORD_COUNT_O=0. Reset mid-operation discards all stored contents.
- Storage: single memory with one write port and a registered read port. An accepted store (STORE_I & STORE_PERM_O) writes mem[wr_ptr]; wr_ptr then increments and wraps modulo TRB_DEPTH.
- Trigger detect: rising edge of TRG_EVENT_I, registered previous value compared with the current one. Only the first edge after reset counts.
- Trace mode states:
  - ARMED: every store is accepted and overwrites the oldest word. fill = min(fill+1, TRB_DEPTH). On the edge: EVENT_ADDR_O <= wr_ptr; EVENT_POS_O <= EVENT_POS_I; dly <= min(TRG_DELAY_I, TRB_DEPTH-1); post <= 0; go to TRIGGERED.
  - TRIGGERED: each accepted store increments post. The store that occurs while post==dly moves the block to DONE in the next cycle. An edge and a store in the same cycle: the store is the event word.
  - DONE: STORE_PERM_O=0 and TRG_DELAYED_O=1, both sticky until reset. rd_ptr <= (fill==TRB_DEPTH) ? wr_ptr : 0. Read-out order is oldest first; WORD_COUNT_O = words not yet granted.
  - In ARMED and TRIGGERED no load is granted and WORD_COUNT_O=0.
- Stream modes (1–3): FIFO.
  - STORE_PERM_O = (count < TRB_DEPTH).
  - A load is granted when count > 0.
  - A store and a grant-causing load in the same cycle leave count unchanged. A store into an empty FIFO is grantable from the next cycle.
  - TRG_DELAYED_O is set on the first trigger edge and stays sticky. EVENT_ADDR_O and EVENT_POS_O are latched as in trace mode.
  - WORD_COUNT_O = count.
- Load handshake:
  - Request is sampled in cycle n with data available and LOAD_GRANT_O=0.
  - Cycle n+1: LOAD_GRANT_O=1 for exactly one cycle, DATA_O = mem[rd_ptr]; rd_ptr and the count decrement at that point.
  - A request still high during the grant cycle is not re-sampled, so the peak grant rate is one every two cycles.
  - DATA_O holds its last value when no grant is active.
  - A request with no data available waits; no grant is issued until data exists.
- Widths: pointers are ADDR_W bits and wrap naturally; count and fill are ADDR_W+1 bits and saturate at TRB_DEPTH.

Test Plan:
1. Trace mode, DEPTH=64, TRG_DELAY_I=3: store words 0..9, event edge before word 10, store words 10..20 → STORE_PERM_O drops after word 13 is stored. TRG_DELAYED_O=1, EVENT_ADDR_O=10. Loads return 0..13 oldest first, then no further grants.
2. Trace mode wrap: store 100 words with values 0..99, event at word 90, TRG_DELAY_I=5 → capture ends at word 95. Read-out returns 32..95 (64 words) and EVENT_ADDR_O=90 mod 64=26.
3. TRG_DELAY_I=63 clamped to 63: event on word 0 → exactly 64 post words including the event word, no overwrite. Event edge and store in the same cycle → EVENT_ADDR_O equals that store's address.
4. Stream mode FIFO: fill to 64 → STORE_PERM_O=0. One load → grant with word 0 one cycle after the request, STORE_PERM_O=1 again. Simultaneous store and grant keeps WORD_COUNT_O constant.
5. Load handshake: request held high on a non-empty FIFO → grants on alternate cycles. Request on empty → no grant; a store arrives → grant occurs two cycles after that store.
6. Reset mid-TRIGGERED → all outputs return to reset values. A new capture starts cleanly and the stale TRG_EVENT_I level does not retrigger without a new rising edge.
